temp_rega: RTL and testbench

TEMP_REGA -- requirements
Module: temp_rega

---
 rtl/temp_rega.sv | 58 +++++
 tb/tb_temp_rega.sv | 133 +++++++++++++
 2 files changed

// File: rtl/temp_rega.sv
// temp_rega: irrigation valve timer counting Tick pulses up to a latched duration
// Ports: Clk/Reset (async, active-high); Start, Pause, Abort, Tick, Dur[3:0] control inputs;
//        Q[3:0] elapsed ticks, Valve (open in RUN), Busy (RUN/PAUSED), Done (one-Clk completion pulse)
module temp_rega (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Pause,
   input  logic       Abort,
   input  logic       Tick,
   input  logic [3:0] Dur,
   output logic [3:0] Q,
   output logic       Valve,
   output logic       Busy,
   output logic       Done
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] PAUSED = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;
   logic [1:0] state;
   logic [3:0] limit;
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         Q     <= 4'd0;
         limit <= 4'd0;
      end else begin
         case (state)
            IDLE: if (Start && !Abort) begin
               limit <= Dur;
               Q     <= 4'd0;
               state <= (Dur != 4'd0) ? RUN : DONE;
            end
            RUN: if (Abort) begin
               state <= IDLE;
               Q     <= 4'd0;
            end else if (Pause) begin
               state <= PAUSED;
            end else if (Tick) begin
               // limit is nonzero in RUN, so Q stops at limit and never wraps
               Q     <= Q + 4'd1;
               state <= (Q == limit - 4'd1) ? DONE : RUN;
            end
            PAUSED: if (Abort) begin
               state <= IDLE;
               Q     <= 4'd0;
            end else if (!Pause) begin
               state <= RUN;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign Valve = state == RUN;
   assign Busy  = (state == RUN) || (state == PAUSED);
   assign Done  = state == DONE;
endmodule

// File: tb/tb_temp_rega.sv
// tb_temp_rega: directed scenarios plus random stimulus checked against a behavioural model
module tb_temp_rega;
   logic       Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Pause = 1'b0, Abort = 1'b0, Tick = 1'b0;
   logic [3:0] Dur = 4'd0;
   logic [3:0] Q;
   logic       Valve, Busy, Done;
   int         n_chk = 0, n_fail = 0, n_done = 0;
   string      scen = "reset";
   bit         m_act, m_pau, m_done;
   int         m_cnt, m_lim;

   temp_rega dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Pause(Pause), .Abort(Abort),
                  .Tick(Tick), .Dur(Dur), .Q(Q), .Valve(Valve), .Busy(Busy), .Done(Done));

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0d expected %0d", scen, tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_pau = 0; m_done = 0; m_cnt = 0; m_lim = 0;
   endtask

   // Timer behaviour: a cycle is active until limit ticks are counted or it is aborted
   task automatic model_step(input bit s, input bit p, input bit a, input bit t, input int d);
      if (m_done) m_done = 0;
      else if (!m_act) begin
         if (s && !a) begin
            m_lim = d; m_cnt = 0;
            if (d == 0) m_done = 1; else begin m_act = 1; m_pau = 0; end
         end
      end else if (a) begin
         m_act = 0; m_pau = 0; m_cnt = 0;
      end else if (m_pau) m_pau = p;
      else if (p) m_pau = 1;
      else if (t) begin
         m_cnt++;
         if (m_cnt == m_lim) begin m_act = 0; m_done = 1; end
      end
   endtask

   task automatic check_outs();
      chk("q", 8'(Q), 8'(m_cnt));
      chk("valve", 8'(Valve), 8'(m_act && !m_pau));
      chk("busy", 8'(Busy), 8'(m_act));
      chk("done", 8'(Done), 8'(m_done));
      if (Done === 1'b1) n_done++;
   endtask

   task automatic cyc(input bit s, input bit p, input bit a, input bit t, input logic [3:0] d);
      Start = s; Pause = p; Abort = a; Tick = t; Dur = d;
      @(posedge Clk);
      model_step(s, p, a, t, int'(d));
      #1;
      check_outs();
   endtask

   initial begin
      #1 Reset = 1'b1;
      model_reset();
      #1 check_outs();
      @(negedge Clk);
      Reset = 1'b0;

      scen = "dur3"; n_done = 0;
      cyc(1, 0, 0, 0, 3);
      chk("start_q", 8'(Q), 8'd0);
      for (int i = 1; i < 20; i++) cyc(0, 0, 0, (i % 4 == 0), 3);
      chk("final_q", 8'(Q), 8'd3);
      chk("done_cnt", 8'(n_done), 8'd1);

      scen = "dur0"; n_done = 0;
      cyc(1, 0, 0, 1, 0);
      chk("in_done", 8'(Done), 8'd1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
      chk("done_cnt", 8'(n_done), 8'd1);
      chk("q0", 8'(Q), 8'd0);

      scen = "pause"; n_done = 0;
      cyc(1, 0, 0, 0, 5);
      for (int i = 0; i < 40 && Q != 4'd2; i++) cyc(0, 0, 0, i[0], 5);
      chk("reach2", 8'(Q), 8'd2);
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 5);
      chk("held_q", 8'(Q), 8'd2);
      chk("held_valve", 8'(Valve), 8'd0);
      chk("held_busy", 8'(Busy), 8'd1);
      for (int i = 0; i < 20 && n_done == 0; i++) cyc(0, 0, 0, 1, 5);
      chk("final_q", 8'(Q), 8'd5);
      chk("done_cnt", 8'(n_done), 8'd1);
      cyc(0, 0, 0, 0, 5);

      scen = "abort"; n_done = 0;
      cyc(1, 0, 0, 0, 8);
      for (int i = 0; i < 20 && Q != 4'd4; i++) cyc(0, 0, 0, 1, 8);
      chk("reach4", 8'(Q), 8'd4);
      cyc(0, 1, 1, 1, 8);
      chk("q0", 8'(Q), 8'd0);
      chk("valve0", 8'(Valve), 8'd0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8);
      chk("done_cnt", 8'(n_done), 8'd0);

      scen = "dur15"; n_done = 0;
      for (int i = 0; i < 40; i++) cyc(1, 0, 0, 1, 15);
      chk("done_cnt", 8'(n_done), 8'd2);

      scen = "areset"; n_done = 0;
      cyc(0, 0, 0, 0, 10);
      cyc(0, 0, 0, 0, 10);
      cyc(1, 0, 0, 0, 10);
      for (int i = 0; i < 20 && Q != 4'd6; i++) cyc(0, 0, 0, 1, 10);
      chk("reach6", 8'(Q), 8'd6);
      #1 Reset = 1'b1;
      model_reset();
      #1 check_outs();
      chk("before_edge", 8'(Clk), 8'd1);
      #1 Reset = 1'b0;
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 10);
      chk("done_cnt", 8'(n_done), 8'd0);

      scen = "random";
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
